// File: rtl/regbank_debug_port.sv
// regbank_debug_port
//   Debug initiator that sits on the register bank's write port and one read port.
//   A load command streams M-1 words into registers 1..M-1 (register 0 is never
//   written). A dump command streams registers 0..M-1 out, one word every two cycles.
//   While a command is in progress, halt_req stalls the core so that the core does
//   not contend for the bank.
//
// Ports
//   clk, rst                          clock and asynchronous active-low reset
//   cmd_valid/cmd_op/cmd_ready        command handshake (cmd_op: 1 = load, 0 = dump)
//   in_valid/in_data/in_ready         load data stream
//   out_valid/out_data/out_last/out_ready  dump data stream (out_last marks reg M-1)
//   done                              one-cycle pulse when a command completes
//   halt_req                          high whenever a command is in progress
//   bank_RegWrite/bank_Wreg/bank_Wdata     bank write port
//   bank_Rreg/bank_Rdata              bank read port (read data is combinational)
module regbank_debug_port #(
    parameter int unsigned N  = 8,
    parameter int unsigned M  = 8,
    localparam int unsigned IW = $clog2(M)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    input  logic          cmd_op,
    output logic          cmd_ready,
    input  logic          in_valid,
    input  logic [N-1:0]  in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [N-1:0]  out_data,
    output logic          out_last,
    input  logic          out_ready,
    output logic          done,
    output logic          halt_req,
    output logic          bank_RegWrite,
    output logic [IW-1:0] bank_Wreg,
    output logic [N-1:0]  bank_Wdata,
    output logic [IW-1:0] bank_Rreg,
    input  logic [N-1:0]  bank_Rdata
);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDumpRd,
        StDumpTx
    } state_e;

    localparam logic [IW-1:0] LastIdx = IW'(M - 1);

    state_e        state;
    logic [IW-1:0] idx;

    // Handshake readies and halt decode straight from the state register, so the
    // asynchronous reset drives them to their idle values immediately.
    assign cmd_ready = (state == StIdle);
    assign in_ready  = (state == StLoad);
    assign halt_req  = (state != StIdle);
    assign bank_Rreg = idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= StIdle;
            idx           <= '0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_last      <= 1'b0;
            done          <= 1'b0;
            bank_RegWrite <= 1'b0;
            bank_Wreg     <= '0;
            bank_Wdata    <= '0;
        end else begin
            // Pulses default low; a write pulse only repeats when the next beat
            // also handshakes.
            done          <= 1'b0;
            bank_RegWrite <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (cmd_valid) begin
                        if (cmd_op) begin
                            idx   <= IW'(1);
                            state <= StLoad;
                        end else begin
                            idx   <= '0;
                            state <= StDumpRd;
                        end
                    end
                end
                StLoad: begin
                    if (in_valid) begin
                        bank_RegWrite <= 1'b1;
                        bank_Wreg     <= idx;
                        bank_Wdata    <= in_data;
                        if (idx == LastIdx) begin
                            // done lands in the same cycle as the final write pulse
                            done  <= 1'b1;
                            state <= StIdle;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                StDumpRd: begin
                    out_data  <= bank_Rdata;
                    out_last  <= (idx == LastIdx);
                    out_valid <= 1'b1;
                    state     <= StDumpTx;
                end
                StDumpTx: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (idx == LastIdx) begin
                            done  <= 1'b1;
                            state <= StIdle;
                        end else begin
                            idx   <= idx + IW'(1);
                            state <= StDumpRd;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
